// File: rtl/i2c_pkg.sv
// Shared types for the I2C register sequencer: FSM states,
// strobe event encoding and the idle/timeout fill byte.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PTR,
        WR_HOLD,
        WR_BUS,
        RD_BUS,
        RD_HOLD
    } state_t;

    typedef enum logic [2:0] {
        EV_NONE,
        EV_ADDR,
        EV_RX,
        EV_TX,
        EV_ERR
    } ev_kind_t;

    typedef struct packed {
        ev_kind_t   kind;
        logic [7:0] data;
    } ev_t;

    localparam int         RW_BIT    = 0;
    localparam logic [7:0] FILL_BYTE = 8'hFF;

endpackage

// File: rtl/i2c_reg_ctrl_if.sv
// I2C slave strobes on one side, register bus on the other.
// The controller uses master; the slave/register bank side uses slave.
interface i2c_reg_ctrl_if #(
    parameter int REG_ADDR_W = 8
);
    logic [7:0]            i2c_addr_rw;
    logic                  i2c_addr_rw_valid_stb;
    logic [7:0]            i2c_data_rx;
    logic                  i2c_data_rx_valid_stb;
    logic                  i2c_data_tx_done_stb;
    logic                  i2c_error_stb;
    logic                  stall;
    logic [7:0]            i2c_data_tx;
    logic [REG_ADDR_W-1:0] reg_addr;
    logic [7:0]            reg_wdata;
    logic                  reg_req;
    logic                  reg_we;
    logic [7:0]            reg_rdata;
    logic                  reg_ack;
    logic                  err_stb;

    modport master (
        input  i2c_addr_rw, i2c_addr_rw_valid_stb,
        input  i2c_data_rx, i2c_data_rx_valid_stb,
        input  i2c_data_tx_done_stb, i2c_error_stb,
        input  reg_rdata, reg_ack,
        output stall, i2c_data_tx,
        output reg_addr, reg_wdata, reg_req, reg_we,
        output err_stb
    );

    modport slave (
        output i2c_addr_rw, i2c_addr_rw_valid_stb,
        output i2c_data_rx, i2c_data_rx_valid_stb,
        output i2c_data_tx_done_stb, i2c_error_stb,
        output reg_rdata, reg_ack,
        input  stall, i2c_data_tx,
        input  reg_addr, reg_wdata, reg_req, reg_we,
        input  err_stb
    );

endinterface

// File: rtl/i2c_reg_ptr.sv
// Register pointer: load from the first written byte,
// increment after each access, wraps modulo 2^W.
module i2c_reg_ptr #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         inc,
    input  logic [W-1:0] din,
    output logic [W-1:0] ptr
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= din;
        end else if (inc) begin
            ptr <= ptr + W'(1);
        end
    end

endmodule

// File: rtl/i2c_reg_ctrl.sv
// I2C byte strobes to register read/write sequencer with clock stretch.
// Optional access timeout: define I2C_REG_CTRL_TIMEOUT_EN.
module i2c_reg_ctrl
    import i2c_pkg::*;
#(
    parameter logic [6:0] I2C_ADDRESS = 7'h42,
    parameter int         REG_ADDR_W  = 8,
    parameter int         ACK_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    i2c_reg_ctrl_if.master bus
);

    state_t          state;
    ev_t             pend;
    ev_t             live_ev;
    ev_t             ev;
    logic            stall_q;
    logic [7:0]      tx_q;
    logic            req_q;
    logic            we_q;
    logic [7:0]      wdata_q;
    logic            in_bus;
    logic            addr_hit;
    logic            tmo;
    logic            access_done;
    logic            ptr_load;
    logic            ptr_inc;
    logic [REG_ADDR_W-1:0] ptr;

    // One strobe per cycle is expected; error wins if they collide.
    always_comb begin
        live_ev.kind = EV_NONE;
        live_ev.data = 8'h00;
        if (bus.i2c_error_stb) begin
            live_ev.kind = EV_ERR;
        end else if (bus.i2c_addr_rw_valid_stb) begin
            live_ev.kind = EV_ADDR;
            live_ev.data = bus.i2c_addr_rw;
        end else if (bus.i2c_data_rx_valid_stb) begin
            live_ev.kind = EV_RX;
            live_ev.data = bus.i2c_data_rx;
        end else if (bus.i2c_data_tx_done_stb) begin
            live_ev.kind = EV_TX;
        end
    end

    assign in_bus = (state == WR_BUS) || (state == RD_BUS);
    assign ev = (live_ev.kind != EV_NONE) ? live_ev : pend;
    assign addr_hit = (ev.data[7:1] == I2C_ADDRESS);
    assign access_done = req_q && (bus.reg_ack || tmo);

    assign ptr_load = (state == PTR) && (ev.kind == EV_RX);
    assign ptr_inc = ((state == WR_BUS) && access_done)
                  || ((state == RD_HOLD) && (ev.kind == EV_TX));

    i2c_reg_ptr #(
        .W(REG_ADDR_W)
    ) u_ptr (
        .clk (clk),
        .rst (rst),
        .load(ptr_load),
        .inc (ptr_inc),
        .din (ev.data[REG_ADDR_W-1:0]),
        .ptr (ptr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pend      <= '{kind: EV_NONE, data: 8'h00};
            stall_q   <= 1'b0;
            tx_q      <= FILL_BYTE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            wdata_q   <= 8'h00;
        end else if (in_bus) begin
            // Accesses are never aborted; park any strobe until done.
            if (live_ev.kind != EV_NONE) begin
                pend <= live_ev;
            end
            if (access_done) begin
                req_q   <= 1'b0;
                stall_q <= 1'b0;
                if (state == RD_BUS) begin
                    tx_q  <= bus.reg_ack ? bus.reg_rdata : FILL_BYTE;
                    state <= RD_HOLD;
                end else begin
                    state <= WR_HOLD;
                end
            end
        end else begin
            pend <= '{kind: EV_NONE, data: 8'h00};
            unique case (ev.kind)
                EV_ERR: state <= IDLE;
                EV_ADDR: begin
                    if (!addr_hit) begin
                        state <= IDLE;
                    end else if (ev.data[RW_BIT]) begin
                        state   <= RD_BUS;
                        req_q   <= 1'b1;
                        we_q    <= 1'b0;
                        stall_q <= 1'b1;
                    end else begin
                        state <= PTR;
                    end
                end
                EV_RX: begin
                    if (state == PTR) begin
                        state <= WR_HOLD;
                    end else if (state == WR_HOLD) begin
                        wdata_q <= ev.data;
                        state   <= WR_BUS;
                        req_q   <= 1'b1;
                        we_q    <= 1'b1;
                        stall_q <= 1'b1;
                    end
                end
                EV_TX: begin
                    if (state == RD_HOLD) begin
                        state   <= RD_BUS;
                        req_q   <= 1'b1;
                        we_q    <= 1'b0;
                        stall_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef I2C_REG_CTRL_TIMEOUT_EN
    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    logic [CW-1:0] tmo_cnt;
    logic          err_q;

    assign tmo = req_q && !bus.reg_ack
              && (tmo_cnt == CW'(ACK_TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= tmo;
            if (!req_q || access_done) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + CW'(1);
            end
        end
    end

    assign bus.err_stb = err_q;
`else
    localparam int unused_ack_timeout = ACK_TIMEOUT;

    assign tmo         = 1'b0;
    assign bus.err_stb = 1'b0;
`endif

    assign bus.stall       = stall_q;
    assign bus.i2c_data_tx = tx_q;
    assign bus.reg_req     = req_q;
    assign bus.reg_we      = we_q;
    assign bus.reg_wdata   = wdata_q;
    assign bus.reg_addr    = ptr;

endmodule

// File: doc/i2c_reg_ctrl.md
# i2c_reg_ctrl

Sequencer that sits between `i2c_simple_slave` and a memory-mapped register bank, turning I2C byte strobes into register read/write requests. The first byte written after a matching write address sets an internal register pointer. Later written bytes are stored at the pointer, and read transactions stream register contents; the pointer auto-increments after each byte. The block drives the slave's `stall` input so the slave stretches SCL while a register access is outstanding.

## Interface
- `I2C_ADDRESS`, 7'h42: 7-bit device address; must match the slave instance.
- `REG_ADDR_W`, 8: register address width, 1..8.
- `ACK_TIMEOUT`, 255: cycles to wait for `reg_ack` before abandoning an access (timeout build only).

- `clk` input 1: system clock.
- `rst` input 1: reset, asynchronous, active-high.
- `i2c_addr_rw` input 8: {addr[6:0], R/W̄} from the slave.
- `i2c_addr_rw_valid_stb` input 1: address byte received.
- `i2c_data_rx` input 8: received data byte.
- `i2c_data_rx_valid_stb` input 1: data byte received.
- `i2c_data_tx_done_stb` input 1: transmit byte shifted out.
- `i2c_error_stb` input 1: slave protocol error.
- `stall` output 1: holds the slave in clock stretch.
- `i2c_data_tx` output 8: next byte the slave transmits.
- `reg_addr` output REG_ADDR_W: register address.
- `reg_wdata` output 8: write data.
- `reg_req` output 1: access request, held until acknowledged.
- `reg_we` output 1: 1 = write, 0 = read; valid while `reg_req` is high.
- `reg_rdata` input 8: read data, sampled when `reg_ack` is high.
- `reg_ack` input 1: one-cycle access completion.
- `err_stb` output 1: one-cycle pulse on timeout.

## Operation
- States: IDLE, PTR, WR_HOLD, WR_BUS, RD_BUS, RD_HOLD.
- IDLE, on address strobe:
  - Address mismatch (`addr[7:1] != I2C_ADDRESS`): stay in IDLE; the slave ignores the transaction.
  - R/W̄ = 0: go to PTR.
  - R/W̄ = 1: go to RD_BUS and issue a read at the pointer.
- PTR, on rx strobe: pointer ← `i2c_data_rx[REG_ADDR_W-1:0]`; go to WR_HOLD.
- WR_HOLD, on rx strobe: `reg_wdata` ← byte; go to WR_BUS with `reg_req`=1, `reg_we`=1.
- WR_BUS, on `reg_ack`: pointer +1; go to WR_HOLD.
- RD_BUS, on `reg_ack`: `i2c_data_tx` ← `reg_rdata`; go to RD_HOLD.
- RD_HOLD, on tx_done strobe: pointer +1; go to RD_BUS with a new read. This is a prefetch, so one extra register read occurs after the master's final NACK (acceptable, documented).
- A matching address strobe in PTR, WR_HOLD or RD_HOLD is a repeated start: re-dispatch as from IDLE. The pointer is kept, so write-pointer-then-restart-read works.
- Error strobe in any non-bus state: go to IDLE; the pointer is kept.
- Strobes arriving in WR_BUS/RD_BUS: latch into a one-deep pending slot (a later strobe overwrites an earlier one). Act on it in the cycle after `reg_ack`; the access is never aborted mid-flight.
- Pointer increment wraps modulo 2^REG_ADDR_W. `reg_addr` = pointer.

## Timing
- Reset values:
  - state IDLE
  - pointer 0
  - `stall` 0
  - `i2c_data_tx` 8'hFF
  - `reg_req` 0, `reg_we` 0
  - `reg_wdata` 0
  - `err_stb` 0
- All outputs are registered.
- `stall` and `reg_req` rise in the cycle after the triggering strobe.
- `reg_req` falls, and `stall` falls, in the cycle after `reg_ack` is sampled. `i2c_data_tx` is updated in that same cycle, so the data is valid whenever `stall` = 0 in RD_HOLD.
- Minimum stall length: 2 cycles (zero-wait `reg_ack`). The slave's own one-cycle stall margin covers the release.
- `reg_addr`, `reg_we` and `reg_wdata` are stable for the whole `reg_req` window.
- `reg_ack` while `reg_req` = 0 is ignored.

## Configuration
- `I2C_REG_CTRL_TIMEOUT_EN` defined:
  - A counter runs while `reg_req` = 1.
  - After ACK_TIMEOUT cycles without `reg_ack`: drop `reg_req`, pulse `err_stb`, release `stall`.
  - A timed-out read loads 8'hFF into `i2c_data_tx`; a timed-out write is discarded.
  - The pointer still increments and the FSM proceeds as if `reg_ack` had arrived.
- Not defined: wait for `reg_ack` indefinitely; `err_stb` is tied to 0; no counter is present.

## Structure
- A shared package `i2c_pkg` holds the state enum, the R/W̄ bit index constant, and the 8'hFF idle/timeout fill byte.
- One sub-module is natural: `i2c_reg_ptr`, the pointer register with load, increment and wrap.
- FSM, pending slot and timeout counter live in the top module.

## Test plan
- Write 0x10, then 0xAA, 0xBB to the matching address → writes to reg 0x10 = 0xAA and reg 0x11 = 0xBB; `stall` is high during each `reg_req`.
- Write pointer 0x20, repeated start, read 3 bytes (regs hold 0x01/0x02/0x03) → `i2c_data_tx` is 0x01, 0x02, 0x03 in sequence, and a fourth prefetch read occurs at 0x23.
- Address 0x43 write → no `reg_req`, `stall` stays 0, state stays IDLE.
- Pointer 0xFF with REG_ADDR_W = 8, write two bytes → addresses 0xFF then 0x00.
- Read with `reg_ack` delayed 40 cycles → `stall` is high for 41 cycles and `reg_req` is stable throughout; an error strobe injected mid-wait takes effect only after the ack.
- Timeout build, ACK_TIMEOUT = 16, no `reg_ack` → `err_stb` pulses at cycle 16, `i2c_data_tx` = 0xFF, `stall` released.
